// File: rtl/pair_serializer.sv
// Pair FIFO feeding an internal 16-bit 2:1 word mux; each (A, B) pair is emitted as A then B.
// Optional PAIR_COUNT_EN adds a 16-bit completed-pair counter on port pair_count.

module pair_serializer_mux #(
  parameter int WIDTH = 16
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = sel ? b : a;
endmodule

module pair_serializer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
`ifdef PAIR_COUNT_EN
  ,output logic [15:0]     pair_count
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {
    SEND_A = 1'b0,
    SEND_B = 1'b1
  } phase_e;

  phase_e           phase_q, phase_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_a_q [DEPTH];
  logic [WIDTH-1:0] mem_a_d [DEPTH];
  logic [WIDTH-1:0] mem_b_q [DEPTH];
  logic [WIDTH-1:0] mem_b_d [DEPTH];
  logic [WIDTH-1:0] mux_y;

  logic push;
  logic word_hs;
  logic pop;

  // Handshake flags derive only from registered state, so in_ready never depends on out_ready.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign word_hs   = out_valid && out_ready;
  assign pop       = word_hs && (phase_q == SEND_B);

  pair_serializer_mux #(
    .WIDTH(WIDTH)
  ) u_mux (
    .sel(phase_q == SEND_B),
    .a  (mem_a_q[rd_ptr_q]),
    .b  (mem_b_q[rd_ptr_q]),
    .y  (mux_y)
  );

  assign out_data = out_valid ? mux_y : '0;
  assign out_last = out_valid && (phase_q == SEND_B);

  always_comb begin
    mem_a_d  = mem_a_q;
    mem_b_d  = mem_b_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_a_d[wr_ptr_q] = in_a;
      mem_b_d[wr_ptr_q] = in_b;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      SEND_A:  if (word_hs) phase_d = SEND_B;
      SEND_B:  if (word_hs) phase_d = SEND_A;
      default: phase_d = SEND_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= SEND_A;
    end else begin
      phase_q <= phase_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_a_q[i] <= '0;
        mem_b_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_a_q  <= mem_a_d;
      mem_b_q  <= mem_b_d;
    end
  end

`ifdef PAIR_COUNT_EN
  logic [15:0] pair_count_q, pair_count_d;

  // Counts on the B-word handshake; wraps naturally at 16 bits.
  always_comb begin
    pair_count_d = pair_count_q;
    if (pop) pair_count_d = pair_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_count_q <= '0;
    end else begin
      pair_count_q <= pair_count_d;
    end
  end

  assign pair_count = pair_count_q;
`endif

endmodule
